// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul front end: feeder FSM states,
// default array geometry and the flush length.
package matmul_pkg;

    localparam int DEFAULT_N  = 4;
    localparam int DEFAULT_W  = 8;
    localparam int DEFAULT_KW = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DRAIN
    } feeder_state_t;

    // The array empties in 2N cycles: N of skew, N-1 of PE hops and 1 of accumulate.
    function automatic int flush_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Joint A/B operand handshake into the feeder. One beat carries an A column and a B row.
interface systolic_feeder_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;

    modport master (output in_valid, output a_in, output b_in, input  in_ready);
    modport slave  (input  in_valid, input  a_in, input  b_in, output in_ready);
endinterface

// File: rtl/skew_line.sv
// Valid+data delay line of DEPTH registered stages; the output is the last stage.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int s = 1; s < DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    // NOTE: every stage is reset, not just the valid bits, because downstream
    // logic relies on edge data being zero whenever its valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's old value.
            valid_q <= valid_d;
            for (int s = 0; s < DEPTH; s++) data_q[s] <= data_d[s];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds an N x N output-stationary PE array: sequences clear/stream/flush/drain
// for one C-block and applies the triangular skew to the A and B edges.
module systolic_feeder
    import matmul_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int KW = DEFAULT_KW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    output logic              busy,
    output logic              done,
    systolic_feeder_if.slave  s_if,
    output logic [N*W-1:0]    a_edge,
    output logic [N-1:0]      a_edge_valid,
    output logic [N*W-1:0]    b_edge,
    output logic [N-1:0]      b_edge_valid,
    output logic              acc_clear_block,
    output logic              drain_en
);

    localparam int FLUSH_LEN = flush_cycles(N);
    localparam int FCW       = $clog2(2 * N + 1);

    feeder_state_t   state_q, state_d;
    logic [KW-1:0]   k_len_q, k_len_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            xfer;

    assign xfer = s_if.in_valid && (state_q == STREAM);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                beat_cnt_d  = '0;
                flush_cnt_d = '0;
                state_d     = (k_len_q == '0) ? FLUSH : STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_q + KW'(1) == k_len_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FCW'(1);
                if (flush_cnt_q == FCW'(FLUSH_LEN - 1)) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign s_if.in_ready   = (state_q == STREAM);
    assign acc_clear_block = (state_q == CLEAR);
    assign drain_en        = (state_q == DRAIN);
    assign done            = (state_q == DRAIN);

    // Lane i sits i+1 registers from the input so operands meet in the right PE.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_lane, b_lane;
        assign a_lane = xfer ? s_if.a_in[i*W +: W] : '0;
        assign b_lane = xfer ? s_if.b_in[i*W +: W] : '0;

        skew_line #(.W(W), .DEPTH(i + 1)) u_a_skew (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (xfer),
            .in_data   (a_lane),
            .out_valid (a_edge_valid[i]),
            .out_data  (a_edge[i*W +: W])
        );

        skew_line #(.W(W), .DEPTH(i + 1)) u_b_skew (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (xfer),
            .in_data   (b_lane),
            .out_valid (b_edge_valid[i]),
            .out_data  (b_edge[i*W +: W])
        );
    end

endmodule
